reg_bank_write_arbiter: RTL and testbench

- Shares one bank of NREG enable-gated D flip-flop registers (WIDTH bits each) between two write requesters, A and B.
- Each cycle it picks at most one requester using round-robin priority.
- It drives a one-hot write enable to the addressed register and a registered data bus to all register D inputs.
- It sits between the requesters and the register bank; the register bank itself stays outside this block.

---
 rtl/reg_bank_write_arbiter.sv | 88 ++++++++
 tb/tb_reg_bank_write_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_write_arbiter.sv
// Write arbiter for a shared bank of enable-gated registers.
// Two requesters (A and B) compete for a single write slot per cycle.
// Round-robin priority decides ties. The winner's one-hot enable and
// data are registered and presented to the bank one cycle after the
// request is sampled.
module reg_bank_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             req_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] d_a,
    input  logic             req_b,
    input  logic [AW-1:0]    addr_b,
    input  logic [WIDTH-1:0] d_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [NREG-1:0]  en,
    output logic [WIDTH-1:0] d_out,
    output logic             err
);

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    logic             state;
    logic             state_next;
    logic             last;
    logic             grant_now;
    logic             pick_b;
    logic [AW-1:0]    win_addr;
    logic [WIDTH-1:0] win_data;
    logic             win_oob;
    logic [NREG-1:0]  win_en;

    // Select this cycle's winner and decode its enable. B wins only when
    // it is the sole requester or A was the most recent winner.
    always_comb begin
        grant_now  = !hold && (req_a || req_b);
        pick_b     = req_b && (!req_a || (last == SEL_A));
        win_addr   = pick_b ? addr_b : addr_a;
        win_data   = pick_b ? d_b : d_a;
        win_oob    = ({1'b0, win_addr} >= (AW + 1)'(NREG));
        win_en     = '0;
        for (int i = 0; i < NREG; i++) begin
            win_en[i] = (win_addr == AW'(i));
        end
        state_next = grant_now ? GRANT : IDLE;
    end

    // Register the grant slot. The pointer moves only on an issued grant,
    // so hold and idle cycles keep the fairness order intact. An
    // out-of-range target still releases the requester but raises err.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= SEL_B;
            en    <= '0;
            d_out <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_now) begin
                last  <= pick_b;
                en    <= win_en;
                d_out <= win_data;
                if (win_oob) begin
                    err <= 1'b1;
                end
            end else begin
                en <= '0;
            end
        end
    end

    // In GRANT, the pointer has just been updated to the winner, so it
    // identifies which grant pulse to raise.
    assign gnt_a = (state == GRANT) && (last == SEL_A);
    assign gnt_b = (state == GRANT) && (last == SEL_B);

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter, instantiated with three registers so
// that address 3 is out of range. It applies directed vector rows,
// followed by random traffic checked against a reference model.
module tb_reg_bank_write_arbiter;

    localparam int WIDTH = 8;
    localparam int NREG  = 3;
    localparam int AW    = 2;

    logic             clk;
    logic             reset;
    logic             hold;
    logic             req_a;
    logic [AW-1:0]    addr_a;
    logic [WIDTH-1:0] d_a;
    logic             req_b;
    logic [AW-1:0]    addr_b;
    logic [WIDTH-1:0] d_b;
    logic             gnt_a;
    logic             gnt_b;
    logic [NREG-1:0]  en;
    logic [WIDTH-1:0] d_out;
    logic             err;

    typedef struct {
        int rst;
        int hld;
        int ra;
        int aa;
        int da;
        int rb;
        int ab;
        int db;
        int ga;
        int gb;
        int een;
        int edo;
        int eer;
    } vec_t;

    vec_t vecs[$];

    int checks;
    int errors;

    // Reference model: a record of who wrote most recently, plus the
    // bus values visible after the latest edge.
    int mLastWasB;
    int mGntA;
    int mGntB;
    int mEn;
    int mDout;
    int mErr;

    reg_bank_write_arbiter #(
        .WIDTH(WIDTH),
        .NREG (NREG),
        .AW   (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .req_a (req_a),
        .addr_a(addr_a),
        .d_a   (d_a),
        .req_b (req_b),
        .addr_b(addr_b),
        .d_b   (d_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .en    (en),
        .d_out (d_out),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, according to the arbitration rules: a reset wipes
    // everything; otherwise, any unheld request yields exactly one writer.
    function automatic void modelStep();
        int winB;
        int addr;
        if (reset) begin
            mGntA     = 0;
            mGntB     = 0;
            mEn       = 0;
            mDout     = 0;
            mErr      = 0;
            mLastWasB = 1;
        end else if (!hold && (req_a || req_b)) begin
            if (req_a && req_b) winB = (mLastWasB != 0) ? 0 : 1;
            else winB = req_b ? 1 : 0;
            addr      = winB ? int'(addr_b) : int'(addr_a);
            mDout     = winB ? int'(d_b) : int'(d_a);
            mGntA     = winB ? 0 : 1;
            mGntB     = winB;
            mEn       = (addr < NREG) ? (1 << addr) : 0;
            if (addr >= NREG) mErr = 1;
            mLastWasB = winB;
        end else begin
            mGntA = 0;
            mGntB = 0;
            mEn   = 0;
        end
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset  = (v.rst != 0);
        hold   = (v.hld != 0);
        req_a  = (v.ra != 0);
        addr_a = AW'(v.aa);
        d_a    = WIDTH'(v.da);
        req_b  = (v.rb != 0);
        addr_b = AW'(v.ab);
        d_b    = WIDTH'(v.db);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    function automatic void checkField(string tag, string field, logic [31:0] got, int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("[TB] FAIL %s %s: got %0h expected %0h", tag, field, got, exp);
        end
    endfunction

    task automatic checkOutput(input string tag, input int eGa, input int eGb,
                               input int eEn, input int eDout, input int eErr);
        checkField(tag, "gnt_a", 32'(gnt_a), eGa);
        checkField(tag, "gnt_b", 32'(gnt_b), eGb);
        checkField(tag, "en", 32'(en), eEn);
        checkField(tag, "d_out", 32'(d_out), eDout);
        checkField(tag, "err", 32'(err), eErr);
        checks++;
        if ((gnt_a && gnt_b) || ($countones(en) > 1)) begin
            errors++;
            $display("[TB] FAIL %s exclusivity: got gnt_a=%0b gnt_b=%0b en=%b expected at most one", tag, gnt_a, gnt_b, en);
        end
    endtask

    initial begin
        vec_t r;
        checks    = 0;
        errors    = 0;
        mLastWasB = 1;
        mGntA     = 0;
        mGntB     = 0;
        mEn       = 0;
        mDout     = 0;
        mErr      = 0;
        reset     = 1'b1;
        hold      = 1'b0;
        req_a     = 1'b0;
        addr_a    = '0;
        d_a       = '0;
        req_b     = 1'b0;
        addr_b    = '0;
        d_b       = '0;

        //              rst hld ra aa  da   rb ab  db   ga gb en      dout  err
        // Reset with both requesting, then the first tie goes to A
        vecs.push_back('{1, 0, 1, 1, 'h11, 1, 2, 'h22, 0, 0, 0,     'h00, 0});
        vecs.push_back('{1, 0, 1, 1, 'h11, 1, 2, 'h22, 0, 0, 0,     'h00, 0});
        vecs.push_back('{0, 0, 1, 1, 'h11, 1, 2, 'h22, 1, 0, 'b010, 'h11, 0});
        // Single write, then idle keeps d_out
        vecs.push_back('{0, 0, 1, 2, 'hA5, 0, 0, 'h00, 1, 0, 'b100, 'hA5, 0});
        vecs.push_back('{0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 0,     'hA5, 0});
        // Reset, then continuous contention alternates A,B,...
        vecs.push_back('{1, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 0,     'h00, 0});
        vecs.push_back('{0, 0, 1, 0, 'h01, 1, 2, 'h02, 1, 0, 'b001, 'h01, 0});
        vecs.push_back('{0, 0, 1, 0, 'h01, 1, 2, 'h02, 0, 1, 'b100, 'h02, 0});
        vecs.push_back('{0, 0, 1, 0, 'h01, 1, 2, 'h02, 1, 0, 'b001, 'h01, 0});
        vecs.push_back('{0, 0, 1, 0, 'h01, 1, 2, 'h02, 0, 1, 'b100, 'h02, 0});
        vecs.push_back('{0, 0, 1, 0, 'h01, 1, 2, 'h02, 1, 0, 'b001, 'h01, 0});
        vecs.push_back('{0, 0, 1, 0, 'h01, 1, 2, 'h02, 0, 1, 'b100, 'h02, 0});
        // Hold blocks grants without moving the pointer
        vecs.push_back('{0, 1, 1, 0, 'h01, 1, 2, 'h02, 0, 0, 0,     'h02, 0});
        vecs.push_back('{0, 1, 1, 0, 'h01, 1, 2, 'h02, 0, 0, 0,     'h02, 0});
        vecs.push_back('{0, 1, 1, 0, 'h01, 1, 2, 'h02, 0, 0, 0,     'h02, 0});
        vecs.push_back('{0, 0, 1, 0, 'h01, 1, 2, 'h02, 1, 0, 'b001, 'h01, 0});
        vecs.push_back('{0, 0, 1, 0, 'h01, 1, 2, 'h02, 0, 1, 'b100, 'h02, 0});
        // Out-of-range target: grant with no enable, sticky err
        vecs.push_back('{0, 0, 0, 0, 'h00, 1, 3, 'h33, 0, 1, 0,     'h33, 1});
        vecs.push_back('{0, 0, 1, 1, 'h44, 0, 0, 'h00, 1, 0, 'b010, 'h44, 1});
        vecs.push_back('{0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 0,     'h44, 1});
        // Reset alongside requests drops the grant and restores priority
        vecs.push_back('{1, 0, 1, 1, 'h55, 1, 2, 'h66, 0, 0, 0,     'h00, 0});
        vecs.push_back('{0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0, 0,     'h00, 0});
        vecs.push_back('{0, 0, 1, 1, 'h55, 1, 2, 'h66, 1, 0, 'b010, 'h55, 0});
        vecs.push_back('{0, 0, 1, 1, 'h55, 1, 2, 'h66, 0, 1, 'b100, 'h66, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].ga, vecs[i].gb,
                        vecs[i].een, vecs[i].edo, vecs[i].eer);
        end

        // Random traffic against the reference model
        r = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(r);
        checkOutput("rnd_reset", mGntA, mGntB, mEn, mDout, mErr);
        for (int n = 0; n < 400; n++) begin
            r.rst = ($urandom_range(0, 59) == 0) ? 1 : 0;
            r.hld = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r.ra  = ($urandom_range(0, 9) < 6) ? 1 : 0;
            r.aa  = $urandom_range(0, 3);
            r.da  = $urandom_range(0, 255);
            r.rb  = ($urandom_range(0, 9) < 6) ? 1 : 0;
            r.ab  = $urandom_range(0, 3);
            r.db  = $urandom_range(0, 255);
            applyStimulus(r);
            checkOutput($sformatf("rnd%0d", n), mGntA, mGntB, mEn, mDout, mErr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
